ram_dp_clr: RTL and testbench
=============================

Name: ram_dp_clr

Overview:
- Simple dual-port synchronous RAM: one write port and one registered read port, with separate data-in and data-out buses instead of a bidirectional bus.
- A built-in clear engine sweeps every location to INIT_VAL after reset or on request.
- Serves as the sample/peak history store for the VU meter channels, in place of the single-port tri-state RAM.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- ADDR, 8, address width; depth = 2**ADDR.
- INIT_VAL, 0, value written to every location by the clear engine (WIDTH bits).
- RDW_MODE, 0, read-during-write to the same address: 0 = read-old (returns prior contents), 1 = write-through (returns new data).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_clr  in  1  pulse; starts a full clear sweep when the block is ready.
- i_wen  in  1  write enable.
- i_waddr  in  ADDR  write address.
- i_wdata  in  WIDTH  write data.
- i_ren  in  1  read enable.
- i_raddr  in  ADDR  read address.
- o_rdata  out  WIDTH  read data; holds its value between reads.
- o_rvalid  out  1  one-cycle pulse marking o_rdata as new.
- o_ready  out  1  high when user reads and writes are accepted.

Behaviour:
- Reset (i_rst=1 on a clock edge): state <= CLEAR, clear counter <= 0, o_ready=0, o_rvalid=0, o_rdata=0. Memory contents are not reset directly; the clear sweep rewrites them.
- FSM states:
  - CLEAR: each cycle writes INIT_VAL to mem[cnt] and increments cnt. After the cycle that writes address 2**ADDR-1, go to READY (o_ready=1 the next cycle). The sweep takes exactly 2**ADDR cycles.
  - READY: user access is enabled. i_clr=1 sets cnt<=0 and returns to CLEAR; o_ready drops the next cycle.
- While o_ready=0, user writes are dropped, user reads are ignored (o_rvalid stays 0, o_rdata holds), and i_clr is ignored.
- Reset during CLEAR restarts the sweep from address 0. Reset has priority over all other inputs.
- Write: with o_ready=1 and i_wen=1, mem[i_waddr] <= i_wdata at the edge.
- Read latency is 1. With o_ready=1 and i_ren=1 sampled at edge N, o_rdata = mem[i_raddr] and o_rvalid=1 after edge N. o_rvalid returns to 0 after edge N+1 unless another read is issued.
- Read and write to the same address in the same cycle:
  - RDW_MODE=0: o_rdata returns the old contents.
  - RDW_MODE=1: o_rdata returns i_wdata.
  - Either way, the write takes effect.
- Read and write to different addresses in the same cycle are independent.
- i_clr asserted in the same READY cycle as i_wen/i_ren: the user access in that cycle completes, then the block enters CLEAR.
- Counter width is ADDR+1 so the terminal count is detected without wrap ambiguity. Addresses are unsigned with no wrap logic; all 2**ADDR locations are valid.

Optional Feature:
- Macro: RAM_DP_CLR_OUTREG_EN.
- Defined: an extra output pipeline register is added on both o_rdata and o_rvalid. Read latency becomes 2 and read-during-write semantics are unchanged. Reset clears both pipeline stages, and reads in flight at reset are discarded.
- Undefined: read latency is 1, as described above.

Decomposition:
- Package ram_pkg holds:
  - the FSM state typedef (ST_CLEAR, ST_READY);
  - RDW_READ_OLD=0 and RDW_WRITE_THRU=1 constants;
  - a function returning the depth from ADDR.
- One sub-module, ram_clr_ctrl, contains the FSM, the clear counter, and the write-port mux that selects between the clear-engine address/data and the user address/data, and drives o_ready. The storage array and read path stay in the top module.

Test Plan:
- Reset, then idle, with ADDR=4 and INIT_VAL=8'hA5: o_ready rises exactly 16 cycles after i_rst deasserts. Reading addresses 0..15 then returns 8'hA5 each time, with o_rvalid high for 1 cycle per read.
- Write 8'h3C to address 5, then read address 5 on the next cycle: o_rdata=8'h3C one cycle after the read. A read of address 6 still returns 8'hA5.
- Same-cycle write of 8'h77 to address 2 and read of address 2, where address 2 holds 8'h11: RDW_MODE=0 gives o_rdata=8'h11; RDW_MODE=1 gives 8'h77. A following read returns 8'h77 in both modes.
- Pulse i_clr after filling all locations with 8'hFF: o_ready is low for 16 cycles and writes issued during the sweep are dropped. All locations then read 8'hA5.
- Assert i_rst at sweep count 7: the sweep restarts and o_ready rises 16 cycles after the reset cycle, not 9.
- Build with RAM_DP_CLR_OUTREG_EN defined: a read of address 5 holding 8'h3C yields o_rvalid and o_rdata two cycles after i_ren. Back-to-back reads of addresses 1, 2, 3 stream out on consecutive cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the clearable dual-port RAM.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int RDW_READ_OLD   = 0;
    localparam int RDW_WRITE_THRU = 1;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear-sweep FSM and write-port mux: owns the RAM write port while sweeping,
// hands it to the user once every location holds INIT_VAL.
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter int              ADDR     = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_wen,
    input  logic [ADDR-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_mem_we,
    output logic [ADDR-1:0]  o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    output logic             o_ready
);

    // Counter is one bit wider than the address so the terminal count is unambiguous.
    localparam logic [ADDR:0] LAST_CNT = (ADDR+1)'(depth_of(ADDR) - 1);
    localparam logic [ADDR:0] CNT_ONE  = (ADDR+1)'(1);

    state_e          state_q, state_d;
    logic [ADDR:0]   cnt_q, cnt_d;
    logic            clearing;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) state_d = ST_READY;
            end
            ST_READY: begin
                if (i_clr) begin
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign clearing    = (state_q == ST_CLEAR);
    assign o_ready     = (state_q == ST_READY);
    assign o_mem_we    = !i_rst && (clearing || (o_ready && i_wen));
    assign o_mem_addr  = clearing ? cnt_q[ADDR-1:0] : i_waddr;
    assign o_mem_wdata = clearing ? INIT_VAL : i_wdata;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with self-clearing sweep. Define RAM_DP_CLR_OUTREG_EN
// to add an output pipeline stage (read latency 2).
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               ADDR     = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter int               RDW_MODE = RDW_READ_OLD
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_wen,
    input  logic [ADDR-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_ren,
    input  logic [ADDR-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rvalid,
    output logic             o_ready
);

    localparam int unsigned DEPTH = depth_of(ADDR);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             ready;
    logic             rd_acc;
    logic             rd_fwd;
    logic [WIDTH-1:0] rd_word;
    logic             rvalid1_q;
    logic [WIDTH-1:0] rdata1_q;

    ram_clr_ctrl #(
        .WIDTH    (WIDTH),
        .ADDR     (ADDR),
        .INIT_VAL (INIT_VAL)
    ) u_ctrl (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (i_clr),
        .i_wen       (i_wen),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_ready     (ready)
    );

    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
    end

    // Array read sees pre-edge contents, so read-old falls out naturally;
    // write-through needs an explicit bypass of the incoming word.
    assign rd_acc  = ready && i_ren;
    assign rd_fwd  = (RDW_MODE == RDW_WRITE_THRU) && i_wen && (i_waddr == i_raddr);
    assign rd_word = rd_fwd ? i_wdata : mem_q[i_raddr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rvalid1_q <= 1'b0;
            rdata1_q  <= '0;
        end else begin
            rvalid1_q <= rd_acc;
            if (rd_acc) rdata1_q <= rd_word;
        end
    end

`ifdef RAM_DP_CLR_OUTREG_EN
    logic             rvalid2_q;
    logic [WIDTH-1:0] rdata2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rvalid2_q <= 1'b0;
            rdata2_q  <= '0;
        end else begin
            rvalid2_q <= rvalid1_q;
            if (rvalid1_q) rdata2_q <= rdata1_q;
        end
    end

    assign o_rvalid = rvalid2_q;
    assign o_rdata  = rdata2_q;
`else
    assign o_rvalid = rvalid1_q;
    assign o_rdata  = rdata1_q;
`endif

    assign o_ready = ready;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: one read-old and one write-through instance
// driven by the same stimulus, checked against hand-computed values.
module tb_ram_dp_clr;

`ifdef RAM_DP_CLR_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, clr, wen, ren;
    logic [3:0] waddr, raddr;
    logic [7:0] wdata;
    logic [7:0] rdata0, rdata1;
    logic       rvalid0, rvalid1, ready0, ready1;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_dp_clr #(.WIDTH(8), .ADDR(4), .INIT_VAL(8'hA5), .RDW_MODE(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wen(wen), .i_waddr(waddr),
        .i_wdata(wdata), .i_ren(ren), .i_raddr(raddr),
        .o_rdata(rdata0), .o_rvalid(rvalid0), .o_ready(ready0));

    ram_dp_clr #(.WIDTH(8), .ADDR(4), .INIT_VAL(8'hA5), .RDW_MODE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wen(wen), .i_waddr(waddr),
        .i_wdata(wdata), .i_ren(ren), .i_raddr(raddr),
        .o_rdata(rdata1), .o_rvalid(rvalid1), .o_ready(ready1));

    typedef struct {
        logic       wen;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic       ren;
        logic [3:0] raddr;
        logic [7:0] e_old;
        logic [7:0] e_thru;
    } vec_t;

    vec_t tv[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wen = 1'b0; ren = 1'b0; clr = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] e0, input logic [7:0] e1,
                           input string nm);
        ren = 1'b1; raddr = a;
        step();
        ren = 1'b0;
        repeat (LAT-1) step();
        chk({nm, " rvalid0"}, 32'(rvalid0), 32'd1);
        chk({nm, " rvalid1"}, 32'(rvalid1), 32'd1);
        chk({nm, " rdata0"}, 32'(rdata0), 32'(e0));
        chk({nm, " rdata1"}, 32'(rdata1), 32'(e1));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready0 && n < 40) begin
            n++;
            step();
        end
    endtask

    int n;
    logic       cap_v;
    logic [7:0] cap_d0, cap_d1;
    logic [7:0] stream_exp [3];

    initial begin
        tv[0] = '{1'b1, 4'd5, 8'h3C, 1'b0, 4'd0, 8'h00, 8'h00};
        tv[1] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'h3C, 8'h3C};
        tv[2] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'hA5, 8'hA5};
        tv[3] = '{1'b1, 4'd2, 8'h11, 1'b0, 4'd0, 8'h00, 8'h00};
        tv[4] = '{1'b1, 4'd2, 8'h77, 1'b1, 4'd2, 8'h11, 8'h77};
        tv[5] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 8'h77, 8'h77};
        tv[6] = '{1'b1, 4'd3, 8'h42, 1'b1, 4'd4, 8'hA5, 8'hA5};
        tv[7] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h42, 8'h42};
        tv[8] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 8'hA5, 8'hA5};
        stream_exp[0] = 8'hA5; stream_exp[1] = 8'h77; stream_exp[2] = 8'h42;

        rst = 1'b1; idle(); waddr = '0; raddr = '0; wdata = '0;
        step(); step();
        chk("reset ready", 32'(ready0), 32'd0);
        chk("reset rvalid", 32'(rvalid0), 32'd0);
        chk("reset rdata", 32'(rdata0), 32'd0);
        rst = 1'b0;
        wait_ready(n);
        chk("sweep cycles after reset", 32'(n), 32'd16);
        chk("ready1 after reset", 32'(ready1), 32'd1);

        for (int i = 0; i < 16; i++)
            do_read(4'(i), 8'hA5, 8'hA5, $sformatf("init rd%0d", i));
        step();
        chk("rvalid drops", 32'(rvalid0), 32'd0);

        for (int i = 0; i < 9; i++) begin
            wen = tv[i].wen; waddr = tv[i].waddr; wdata = tv[i].wdata;
            ren = tv[i].ren; raddr = tv[i].raddr;
            step();
            idle();
            repeat (LAT-1) step();
            chk($sformatf("tv%0d rvalid", i), 32'(rvalid0), 32'(tv[i].ren));
            if (tv[i].ren) begin
                chk($sformatf("tv%0d rdata0", i), 32'(rdata0), 32'(tv[i].e_old));
                chk($sformatf("tv%0d rdata1", i), 32'(rdata1), 32'(tv[i].e_thru));
            end
        end

        // back-to-back reads of 1,2,3 must stream out on consecutive cycles
        for (int k = 0; k < 4 + LAT; k++) begin
            ren = (k < 3); raddr = 4'(k + 1);
            step();
            if (k - (LAT-1) >= 0 && k - (LAT-1) < 3) begin
                chk($sformatf("stream%0d rvalid", k), 32'(rvalid0), 32'd1);
                chk($sformatf("stream%0d rdata", k), 32'(rdata0), 32'(stream_exp[k-(LAT-1)]));
            end else if (k - (LAT-1) == 3) begin
                chk("stream tail rvalid", 32'(rvalid0), 32'd0);
            end
        end
        idle();

        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; waddr = 4'(i); wdata = 8'hFF;
            step();
        end
        idle();

        // clear pulse together with a read and a write; writes during sweep are dropped
        clr = 1'b1; ren = 1'b1; raddr = 4'd4; wen = 1'b1; waddr = 4'd9; wdata = 8'h55;
        step();
        clr = 1'b0; ren = 1'b0;
        chk("ready low after clr", 32'(ready0), 32'd0);
        n = 0; cap_v = 1'b0; cap_d0 = '0; cap_d1 = '0;
        while (!ready0 && n < 40) begin
            n++;
            if (n == LAT) begin
                cap_v = rvalid0; cap_d0 = rdata0; cap_d1 = rdata1;
            end
            wen = 1'b1; waddr = 4'(n); wdata = 8'hFF;
            step();
        end
        idle();
        chk("clr sweep cycles", 32'(n), 32'd16);
        chk("clr-cycle read rvalid", 32'(cap_v), 32'd1);
        chk("clr-cycle read rdata0", 32'(cap_d0), 32'hFF);
        chk("clr-cycle read rdata1", 32'(cap_d1), 32'hFF);
        for (int i = 0; i < 16; i++)
            do_read(4'(i), 8'hA5, 8'hA5, $sformatf("post clr rd%0d", i));

        wen = 1'b1; waddr = 4'd10; wdata = 8'hFF;
        step();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ready low after mid-sweep reset", 32'(ready0), 32'd0);
        chk("rvalid low after mid-sweep reset", 32'(rvalid0), 32'd0);
        wait_ready(n);
        chk("sweep cycles after mid-sweep reset", 32'(n), 32'd16);
        do_read(4'd10, 8'hA5, 8'hA5, "after restart rd10");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
